// File: rtl/core_pkg.sv
// core_pkg -- shared widths, flag bit positions and the writeback buffer
// entry type for the ALU writeback stage.
//
// Contents:
//   WIDTH, REGS_CODING, FLAGS   datapath, register-address and flag widths
//   NUM_REGS, FIFO_DEPTH        derived register count, writeback buffer depth
//   CARRY/SIGN/OVERFLOW/ZERO    bit positions inside a flag vector
//   wb_entry_t                  one buffered ALU result
//   dest_onehot()               register address to one-hot decode
package core_pkg;

  localparam int WIDTH       = 32;
  localparam int REGS_CODING = 3;
  localparam int FLAGS       = 4;
  localparam int NUM_REGS    = 1 << REGS_CODING;
  localparam int FIFO_DEPTH  = 2;

  localparam int CARRY    = 0;
  localparam int SIGN     = 1;
  localparam int OVERFLOW = 2;
  localparam int ZERO     = 3;

  typedef struct packed {
    logic [REGS_CODING-1:0] dest;
    logic [WIDTH-1:0]       result;
    logic [FLAGS-1:0]       flags;
    logic                   wr_reg;
    logic                   wr_flags;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REGS_CODING-1:0] dest);
    return NUM_REGS'(1) << dest;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if -- ALU result handshake into the writeback stage.
//
// Signals:
//   in_valid     ALU result present               (master -> slave)
//   in_ready     stage can accept a result        (slave -> master)
//   in_dest      destination register             (master -> slave)
//   in_result    result value                     (master -> slave)
//   in_flags     {ZERO, OVERFLOW, SIGN, CARRY}    (master -> slave)
//   in_wr_reg    result writes in_dest            (master -> slave)
//   in_wr_flags  result updates the flags reg     (master -> slave)
interface alu_writeback_if;
  import core_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [REGS_CODING-1:0] in_dest;
  logic [WIDTH-1:0]       in_result;
  logic [FLAGS-1:0]       in_flags;
  logic                   in_wr_reg;
  logic                   in_wr_flags;

  modport master (
    output in_valid, in_dest, in_result, in_flags, in_wr_reg, in_wr_flags,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_dest, in_result, in_flags, in_wr_reg, in_wr_flags,
    output in_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo -- 2-entry in-order buffer of ALU results awaiting writeback.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the buffer)
//   push         store push_entry (caller guarantees count < 2)
//   pop          drop the head (caller guarantees count > 0)
//   push_entry   entry to store
//   head         oldest entry (meaningful when count != 0)
//   tail         youngest entry when full (only with WB_BYPASS_EN)
//   count        number of buffered entries, 0..2
//   pend_mask    one-hot OR of dest over buffered entries with wr_reg set
//
// Build option: WB_BYPASS_EN exposes the second slot for operand bypass.
module wb_fifo
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  wb_entry_t           push_entry,
  output wb_entry_t           head,
`ifdef WB_BYPASS_EN
  output wb_entry_t           tail,
`endif
  output logic [1:0]          count,
  output logic [NUM_REGS-1:0] pend_mask
);

  wb_entry_t  slot0;
  wb_entry_t  slot1;
  logic [1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + 2'd1;
    end else if (pop && !push) begin
      cnt <= cnt - 2'd1;
    end
  end

  // NOTE: payload slots are deliberately not reset; validity comes only from
  // cnt, so clearing the data would cost reset routing for nothing.
  // Slot 0 is always the head; a pop shifts slot 1 down.
  always_ff @(posedge clk) begin
    unique case ({push, pop})
      2'b10: begin
        if (cnt == 2'd0) slot0 <= push_entry;
        else             slot1 <= push_entry;
      end
      2'b01: slot0 <= slot1;
      2'b11: begin
        if (cnt == 2'd1) begin
          slot0 <= push_entry;
        end else begin
          slot0 <= slot1;
          slot1 <= push_entry;
        end
      end
      default: ;
    endcase
  end

  // NOTE: pend_mask gets a default before any conditional update so the
  // always_comb can never infer a latch.
  always_comb begin
    pend_mask = '0;
    if (cnt != 2'd0 && slot0.wr_reg) pend_mask = pend_mask | dest_onehot(slot0.dest);
    if (cnt == 2'd2 && slot1.wr_reg) pend_mask = pend_mask | dest_onehot(slot1.dest);
  end

  assign head  = slot0;
  assign count = cnt;
`ifdef WB_BYPASS_EN
  assign tail  = slot1;
`endif

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback -- writeback stage: buffers ALU results in a 2-entry FIFO and
// commits one write per cycle into an 8-entry register file and a flags
// register. Load data (mem_*) has priority; while it writes, the FIFO holds.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   up (slave)             ALU result handshake, see alu_writeback_if
//   mem_valid/dest/data    load-data write request
//   rd_a_addr, rd_b_addr   operand read addresses
//   rd_a_data, rd_b_data   combinational operand read data
//   flags_out              architectural flags register
//   pend_mask              registers targeted by buffered wr_reg entries
//
// Build option: WB_BYPASS_EN makes the read ports forward mem_data and
// buffered results; without it they return the register file only and
// upstream must stall on pend_mask.
module alu_writeback #(
  parameter int WIDTH       = 32,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_writeback_if.slave            up,
  input  logic                      mem_valid,
  input  logic [REGS_CODING-1:0]    mem_dest,
  input  logic [WIDTH-1:0]          mem_data,
  input  logic [REGS_CODING-1:0]    rd_a_addr,
  input  logic [REGS_CODING-1:0]    rd_b_addr,
  output logic [WIDTH-1:0]          rd_a_data,
  output logic [WIDTH-1:0]          rd_b_data,
  output logic [FLAGS-1:0]          flags_out,
  output logic [2**REGS_CODING-1:0] pend_mask
);
  import core_pkg::wb_entry_t;

  logic [WIDTH-1:0] regs [2**REGS_CODING];
  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic [1:0]       count;
  logic             push;
  logic             pop;
`ifdef WB_BYPASS_EN
  wb_entry_t        tail;
`endif

  assign up.in_ready = (count < 2'd2) && !rst;
  assign push        = up.in_valid && up.in_ready;
  // A load write blocks the FIFO for this cycle; the head waits.
  assign pop         = !mem_valid && (count != 2'd0);

  assign push_entry = '{dest:     up.in_dest,
                        result:   up.in_result,
                        flags:    up.in_flags,
                        wr_reg:   up.in_wr_reg,
                        wr_flags: up.in_wr_flags};

  wb_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
`ifdef WB_BYPASS_EN
    .tail       (tail),
`endif
    .count      (count),
    .pend_mask  (pend_mask)
  );

  // The register file is architecturally cleared by reset, so it is built
  // from resettable flops rather than a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 2**REGS_CODING; r++) regs[r] <= '0;
      flags_out <= '0;
    end else if (mem_valid) begin
      regs[mem_dest] <= mem_data;
    end else if (pop) begin
      if (head.wr_reg)   regs[head.dest] <= head.result;
      if (head.wr_flags) flags_out       <= head.flags;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [REGS_CODING-1:0] addr);
`ifdef WB_BYPASS_EN
    // Youngest producer wins: load data, then the newer FIFO slot, then the head.
    if (mem_valid && mem_dest == addr)                      return mem_data;
    if (count == 2'd2 && tail.wr_reg && tail.dest == addr)  return tail.result;
    if (count != 2'd0 && head.wr_reg && head.dest == addr)  return head.result;
`endif
    return regs[addr];
  endfunction

  always_comb begin
    rd_a_data = read_port(rd_a_addr);
    rd_b_data = read_port(rd_b_addr);
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback -- directed scenarios followed by randomized traffic, all
// checked against a transaction-level model (queue of pending results plus
// an array of register values). Build with or without WB_BYPASS_EN.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [2:0]  mem_dest;
  logic [31:0] mem_data;
  logic [2:0]  rd_a_addr, rd_b_addr;
  logic [31:0] rd_a_data, rd_b_data;
  logic [3:0]  flags_out;
  logic [7:0]  pend_mask;

  alu_writeback_if bus ();

  alu_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .up        (bus),
    .mem_valid (mem_valid),
    .mem_dest  (mem_dest),
    .mem_data  (mem_data),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .flags_out (flags_out),
    .pend_mask (pend_mask)
  );

  always #10 clk = ~clk;

  // Reference model: pending ALU results in arrival order, architectural state.
  typedef struct {
    logic [2:0]  dest;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        wr_reg;
    logic        wr_flags;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_regs [8];
  logic [3:0]  m_flags;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 8; r++) m_regs[r] = '0;
    m_flags = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
`ifdef WB_BYPASS_EN
    if (mem_valid && mem_dest == a) return mem_data;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].wr_reg && q[i].dest == a) return q[i].result;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [7:0] exp_pend();
    logic [7:0] m = '0;
    foreach (q[i]) if (q[i].wr_reg) m[q[i].dest] = 1'b1;
    return m;
  endfunction

  // One rising edge as the model sees it: load write wins, else pop the
  // oldest result; an accepted result joins the back of the queue.
  task automatic model_edge();
    ent_t e;
    logic accept;
    if (rst) return;
    accept = bus.in_valid && (q.size() < 2);
    if (mem_valid) begin
      m_regs[mem_dest] = mem_data;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      if (e.wr_reg)   m_regs[e.dest] = e.result;
      if (e.wr_flags) m_flags = e.flags;
    end
    if (accept) begin
      e.dest     = bus.in_dest;
      e.result   = bus.in_result;
      e.flags    = bus.in_flags;
      e.wr_reg   = bus.in_wr_reg;
      e.wr_flags = bus.in_wr_flags;
      q.push_back(e);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model; sweeps both read ports over all
  // registers (takes 8 time units, stays clear of the rising edge).
  task automatic check_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'(!rst && q.size() < 2));
    check({tag, "_pend"},  32'(pend_mask),    32'(exp_pend()));
    check({tag, "_flags"}, 32'(flags_out),    32'(m_flags));
    for (int r = 0; r < 8; r++) begin
      rd_a_addr = 3'(r);
      rd_b_addr = 3'(7 - r);
      #1;
      check({tag, "_rda"}, rd_a_data, exp_rd(3'(r)));
      check({tag, "_rdb"}, rd_b_data, exp_rd(3'(7 - r)));
    end
  endtask

  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic iv, input logic [2:0] d, input logic [31:0] res,
                       input logic [3:0] fl, input logic wr, input logic wf,
                       input logic mv, input logic [2:0] md, input logic [31:0] mdata);
    bus.in_valid    = iv;
    bus.in_dest     = d;
    bus.in_result   = res;
    bus.in_flags    = fl;
    bus.in_wr_reg   = wr;
    bus.in_wr_flags = wf;
    mem_valid       = mv;
    mem_dest        = md;
    mem_data        = mdata;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic read_a(input logic [2:0] a, input string tag, input logic [31:0] exp);
    rd_a_addr = a;
    #1;
    check(tag, rd_a_data, exp);
  endtask

  initial begin
    logic [31:0] exp_v;
    rd_a_addr = '0;
    rd_b_addr = '0;
    idle();
    rst = 1'b1;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First edge after reset accepts; result visible one edge later.
    drive(1'b1, 3'd3, 32'h1234_5678, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    cycle("acc3");
    idle();
    #1;
    check("pend_after_accept", 32'(pend_mask), 32'h08);
    cycle("commit3");
    check("pend_after_commit", 32'(pend_mask), 32'h00);
    read_a(3'd3, "reg3_committed", 32'h1234_5678);

    // Load writes hold the FIFO: two accepts, then stall until drained.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd4, 32'h100 + 32'(k), 4'h0, 1'b1, 1'b0, 1'b1, 3'd7, 32'h700 + 32'(k));
      if (k == 2) begin
        #1;
        check("ready_low_when_full", 32'(bus.in_ready), 32'h0);
      end
      cycle("memhold");
    end
    drive(1'b1, 3'd4, 32'h102, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    cycle("drain_full");
    cycle("third_accept");
    idle();
    for (int k = 0; k < 3; k++) cycle("drain");
    read_a(3'd4, "order_last_wins", 32'h102);
    read_a(3'd7, "mem_last", 32'h702);

    // Load and buffered result to the same register: load first, then FIFO.
    drive(1'b1, 3'd5, 32'hB, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    cycle("acc5");
    drive(1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5, 32'hA);
    cycle("mem5");
    idle();
`ifdef WB_BYPASS_EN
    exp_v = 32'hB;
`else
    exp_v = 32'hA;
`endif
    read_a(3'd5, "reg5_after_mem", exp_v);
    cycle("fifo5");
    read_a(3'd5, "reg5_after_fifo", 32'hB);

    // Compare entry: flags only.
    drive(1'b1, 3'd6, 32'hDEAD, 4'b1000, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
    cycle("cmp_acc");
    idle();
    #1;
    check("cmp_pend", 32'(pend_mask), 32'h0);
    cycle("cmp_commit");
    check("cmp_flags", 32'(flags_out), 32'h8);
    read_a(3'd6, "cmp_reg6", 32'h0);

    // Buffered value for r2 visible on the read port only with bypass.
    drive(1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h11);
    cycle("seed2");
    drive(1'b1, 3'd2, 32'h55, 4'h0, 1'b1, 1'b0, 1'b1, 3'd7, 32'h77);
    cycle("acc2");
    bus.in_valid = 1'b0;
`ifdef WB_BYPASS_EN
    exp_v = 32'h55;
`else
    exp_v = 32'h11;
`endif
    read_a(3'd2, "bypass_r2", exp_v);
    idle();
    cycle("commit2");
    read_a(3'd2, "reg2_final", 32'h55);

    // Reset with the FIFO full: everything clears at once, nothing commits.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'(k), 32'hF0 + 32'(k), 4'hF, 1'b1, 1'b1, 1'b1, 3'd6, 32'h66);
      cycle("fill");
    end
    check("full_before_rst", 32'(bus.in_ready), 32'h0);
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_rst");
    check("post_rst_flags", 32'(flags_out), 32'h0);

    // Randomized traffic with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), $urandom);
      if (n == 200) begin
        rst = 1'b1;
        model_reset();
      end else if (n == 201) begin
        rst = 1'b0;
      end
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
